// File: rtl/pipeline_stall_ctrl.sv
// Hazard/stall sequencer for the 5-stage MIPS pipeline: load-use, mul/div occupancy,
// data-memory wait with timeout, and taken-branch flush. STALL_PERF_CNT_EN adds a stall counter.
module pipeline_stall_ctrl #(
    parameter int unsigned MULDIV_LAT  = 32,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_is_muldiv,
    input  logic        id_reads_hilo,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_dst,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        stall_front,
    output logic        bubble_ex,
    output logic        flush_ifid,
    output logic        freeze_back,
    output logic        muldiv_start,
    output logic        muldiv_busy,
    output logic        mem_err,
    output logic [31:0] perf_stall_cycles
);

    localparam int unsigned MD_W = $clog2(MULDIV_LAT + 1);

    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [MD_W-1:0]  md_cnt;
    logic [MD_W-1:0]  md_nxt;
    logic             hz_ld;
    logic             hz_md;
    logic             mem_hold;

    // Memory wait FSM with sticky timeout error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        state    <= MEMWAIT;
                        wait_cnt <= CNT_W'(1);
                    end
                end
                MEMWAIT: begin
                    if (mem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
                        mem_err  <= 1'b1;
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        mem_hold = (state == RUN) ? (mem_req & ~mem_ready) : ~mem_ready;
        hz_ld    = ex_is_load && (ex_dst != 5'd0) &&
                   ((id_uses_rs && (id_rs == ex_dst)) || (id_uses_rt && (id_rt == ex_dst)));
        hz_md    = muldiv_busy && (id_is_muldiv || id_reads_hilo);
    end

    // Priority: freeze > branch flush > hazard stall > normal issue; all low in reset
    always_comb begin
        stall_front  = 1'b0;
        bubble_ex    = 1'b0;
        flush_ifid   = 1'b0;
        freeze_back  = 1'b0;
        muldiv_start = 1'b0;
        if (!rst_n) begin
            freeze_back = 1'b0;
        end else if (mem_hold) begin
            freeze_back = 1'b1;
            stall_front = 1'b1;
        end else if (ex_branch_taken) begin
            flush_ifid = 1'b1;
            bubble_ex  = 1'b1;
        end else if (hz_ld || hz_md) begin
            stall_front = 1'b1;
            bubble_ex   = 1'b1;
        end else begin
            muldiv_start = id_is_muldiv;
        end
    end

    always_comb begin
        md_nxt = md_cnt;
        if (muldiv_start) begin
            md_nxt = MD_W'(MULDIV_LAT);
        end else if (md_cnt != '0) begin
            md_nxt = md_cnt - MD_W'(1);
        end
    end

    // Mul/div occupancy keeps counting through freezes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt      <= '0;
            muldiv_busy <= 1'b0;
        end else begin
            md_cnt      <= md_nxt;
            muldiv_busy <= (md_nxt != '0);
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if ((stall_front || freeze_back) && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_q;
`else
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl (MULDIV_LAT=4, MEM_TIMEOUT=5).
module tb_pipeline_stall_ctrl;

`ifdef STALL_PERF_CNT_EN
    localparam int unsigned PERF_ON = 1;
`else
    localparam int unsigned PERF_ON = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_is_muldiv;
    logic        id_reads_hilo;
    logic        ex_is_load;
    logic [4:0]  ex_dst;
    logic        ex_branch_taken;
    logic        mem_req;
    logic        mem_ready;
    logic        stall_front;
    logic        bubble_ex;
    logic        flush_ifid;
    logic        freeze_back;
    logic        muldiv_start;
    logic        muldiv_busy;
    logic        mem_err;
    logic [31:0] perf_stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    pipeline_stall_ctrl #(
        .MULDIV_LAT (4),
        .MEM_TIMEOUT(5),
        .CNT_W      (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_uses_rs       (id_uses_rs),
        .id_uses_rt       (id_uses_rt),
        .id_is_muldiv     (id_is_muldiv),
        .id_reads_hilo    (id_reads_hilo),
        .ex_is_load       (ex_is_load),
        .ex_dst           (ex_dst),
        .ex_branch_taken  (ex_branch_taken),
        .mem_req          (mem_req),
        .mem_ready        (mem_ready),
        .stall_front      (stall_front),
        .bubble_ex        (bubble_ex),
        .flush_ifid       (flush_ifid),
        .freeze_back      (freeze_back),
        .muldiv_start     (muldiv_start),
        .muldiv_busy      (muldiv_busy),
        .mem_err          (mem_err),
        .perf_stall_cycles(perf_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_is_muldiv = 1'b0; id_reads_hilo = 1'b0; ex_is_load = 1'b0; ex_dst = 5'd0;
        ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ld(input logic [4:0] dst, input logic [4:0] rs);
        ex_is_load = 1'b1; ex_dst = dst; id_uses_rs = 1'b1; id_rs = rs;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: combinational outputs forced low even with active inputs
        clr();
        rst_n = 1'b0;
        ex_branch_taken = 1'b1; id_is_muldiv = 1'b1; mem_req = 1'b1;
        #3;
        chk("rst_flush",  32'(flush_ifid),   32'd0);
        chk("rst_start",  32'(muldiv_start), 32'd0);
        chk("rst_freeze", 32'(freeze_back),  32'd0);
        chk("rst_busy",   32'(muldiv_busy),  32'd0);
        chk("rst_err",    32'(mem_err),      32'd0);
        chk("rst_perf",   perf_stall_cycles, 32'd0);
        clr();
        #9 rst_n = 1'b1;
        adv();

        // Load-use on rs: one stall cycle, then the bubble clears EX
        set_ld(5'd8, 5'd8);
        @(negedge clk);
        chk("ld_stall",  32'(stall_front), 32'd1);
        chk("ld_bubble", 32'(bubble_ex),   32'd1);
        adv();
        ex_is_load = 1'b0;
        @(negedge clk);
        chk("ld_release", 32'(stall_front), 32'd0);
        chk("ld_nobub",   32'(bubble_ex),   32'd0);
        adv();

        // Load to $zero never stalls
        clr(); set_ld(5'd0, 5'd0);
        @(negedge clk);
        chk("ld_zero", 32'(stall_front), 32'd0);
        adv();

        // rt match stalls; rt match with id_uses_rt=0 does not
        clr(); ex_is_load = 1'b1; ex_dst = 5'd5; id_rt = 5'd5; id_rs = 5'd3; id_uses_rs = 1'b1;
        @(negedge clk);
        chk("ld_rt_unused", 32'(stall_front), 32'd0);
        id_uses_rt = 1'b1;
        #1;
        chk("ld_rt_stall", 32'(stall_front), 32'd1);
        adv();

        // Mul/div: start at cycle 0, MFHI stalls on cycles 1..4
        clr(); id_is_muldiv = 1'b1;
        @(negedge clk);
        chk("md_start", 32'(muldiv_start), 32'd1);
        chk("md_busy0", 32'(muldiv_busy),  32'd0);
        adv();
        clr(); id_reads_hilo = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("md_busy%0d", i),  32'(muldiv_busy), 32'd1);
            chk($sformatf("md_stall%0d", i), 32'(stall_front), 32'd1);
            adv();
        end
        @(negedge clk);
        chk("md_busy5",  32'(muldiv_busy), 32'd0);
        chk("md_stall5", 32'(stall_front), 32'd0);
        adv();

        // Memory wait: 3 frozen cycles, release on the ready cycle
        clr(); mem_req = 1'b1; id_is_muldiv = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk($sformatf("mw_freeze%0d", i), 32'(freeze_back), 32'd1);
            chk($sformatf("mw_stall%0d", i),  32'(stall_front), 32'd1);
            chk($sformatf("mw_nostart%0d", i), 32'(muldiv_start), 32'd0);
            adv();
            id_is_muldiv = 1'b0;
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk("mw_ready_freeze", 32'(freeze_back), 32'd0);
        chk("mw_err",          32'(mem_err),     32'd0);
        adv();

        // Priority: branch over load-use, then freeze over branch
        clr(); set_ld(5'd8, 5'd8); ex_branch_taken = 1'b1; id_is_muldiv = 1'b1;
        @(negedge clk);
        chk("br_flush",  32'(flush_ifid),   32'd1);
        chk("br_bubble", 32'(bubble_ex),    32'd1);
        chk("br_stall",  32'(stall_front),  32'd0);
        chk("br_start",  32'(muldiv_start), 32'd0);
        mem_req = 1'b1;
        #1;
        chk("fz_freeze", 32'(freeze_back), 32'd1);
        chk("fz_stall",  32'(stall_front), 32'd1);
        chk("fz_flush",  32'(flush_ifid),  32'd0);
        chk("fz_bubble", 32'(bubble_ex),   32'd0);
        adv();
        clr(); mem_ready = 1'b1;
        @(negedge clk);
        chk("fz_exit", 32'(freeze_back), 32'd0);
        adv();

        // Timeout: entry cycle plus wait_cnt 1..5, error after the wait_cnt==5 cycle
        clr(); mem_req = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("to_freeze%0d", i), 32'(freeze_back), 32'd1);
            chk($sformatf("to_err%0d", i),    32'(mem_err),     32'd0);
            adv();
        end
        @(negedge clk);
        chk("to_err5", 32'(mem_err), 32'd0);
        adv();
        mem_req = 1'b0;
        @(negedge clk);
        chk("to_err_set",  32'(mem_err),     32'd1);
        chk("to_released", 32'(freeze_back), 32'd0);
        adv(); adv(); adv();
        @(negedge clk);
        chk("to_err_sticky", 32'(mem_err), 32'd1);
        adv();
        #2 rst_n = 1'b0;
        #1;
        chk("to_err_rst", 32'(mem_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        adv();

        // Stall counter: 3 memory wait cycles + 1 load-use cycle
        clr(); mem_req = 1'b1;
        adv(); adv(); adv();
        mem_ready = 1'b1;
        adv();
        clr(); set_ld(5'd9, 5'd9);
        adv();
        ex_is_load = 1'b0;
        @(negedge clk);
        chk("perf_4", perf_stall_cycles, (PERF_ON != 0) ? 32'd4 : 32'd0);
        adv();

        // Async reset in MEMWAIT with a mul/div in flight
        clr(); id_is_muldiv = 1'b1;
        adv();
        clr(); mem_req = 1'b1;
        @(negedge clk);
        chk("ar_busy", 32'(muldiv_busy), 32'd1);
        adv(); adv();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_freeze", 32'(freeze_back),    32'd0);
        chk("ar_perf",   perf_stall_cycles,   32'd0);
        chk("ar_busy0",  32'(muldiv_busy),    32'd0);
        mem_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        id_reads_hilo = 1'b1;
        #1;
        chk("ar_run",     32'(freeze_back), 32'd0);
        chk("ar_nostall", 32'(stall_front), 32'd0);
        adv();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Hazard and stall sequencer for the 5-stage MIPS pipeline. It complements the EX-stage forwarding mux control and resolves the cases forwarding cannot cover:
- load-use hazards
- occupancy of the multi-cycle MULT/DIV unit
- data-memory wait handshake, with timeout
- taken-branch flush
It drives the PC/IF-ID enables, the ID/EX bubble, the back-end freeze and the mul/div start.

Parameters:
MULDIV_LAT, 32, cycles from mul/div start until HI/LO valid (>=2)
MEM_TIMEOUT, 255, max mem wait cycles before error (<=2^CNT_W-1)
CNT_W, 8, width of the memory wait counter

Ports:
clk  in  1  pipeline clock
rst_n  in  1  async active-low reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_is_muldiv  in  1  ID instruction is MULT/MULTU/DIV/DIVU
id_reads_hilo  in  1  ID instruction is MFHI/MFLO
ex_is_load  in  1  EX instruction is a load
ex_dst  in  5  EX destination register
ex_branch_taken  in  1  EX resolved a taken branch/jump
mem_req  in  1  MEM-stage instruction accesses data memory
mem_ready  in  1  data memory completes the access this cycle
stall_front  out  1  hold PC and IF/ID
bubble_ex  out  1  load NOP into ID/EX
flush_ifid  out  1  replace IF/ID with NOP
freeze_back  out  1  hold ID/EX, EX/MEM and MEM/WB (also holds the front)
muldiv_start  out  1  launch mul/div this cycle
muldiv_busy  out  1  mul/div in flight
mem_err  out  1  sticky memory timeout flag
perf_stall_cycles  out  32  stall cycle count (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN, md_cnt=0, wait_cnt=0, mem_err=0.
  - All outputs 0. Combinational outputs are forced to 0 while rst_n=0.
- Memory FSM, states RUN and MEMWAIT:
  - RUN: mem_req & ~mem_ready → next=MEMWAIT, wait_cnt=1. freeze_back=1 in the same cycle (combinational).
  - MEMWAIT: freeze_back = ~mem_ready. If mem_ready=1 → RUN, wait_cnt=0; freeze drops in that cycle.
  - MEMWAIT: else if wait_cnt==MEM_TIMEOUT → mem_err=1 (sticky until reset), RUN. The pipeline is released and the access is treated as complete.
  - MEMWAIT, otherwise: wait_cnt++.
  - mem_req & mem_ready in RUN → no freeze, stay RUN.
- Load-use hazard, hz_ld:
  - ex_is_load & ex_dst!=0 & ((id_uses_rs & id_rs==ex_dst) | (id_uses_rt & id_rt==ex_dst)).
- Mul/div hazard, hz_md:
  - muldiv_busy & (id_is_muldiv | id_reads_hilo).
- Output priority, highest first:
  1. freeze_back=1 → stall_front=1, bubble_ex=0, flush_ifid=0, muldiv_start=0.
  2. ex_branch_taken → flush_ifid=1, bubble_ex=1, stall_front=0, muldiv_start=0. Hazards are ignored because the ID instruction is wrong-path.
  3. hz_ld | hz_md → stall_front=1, bubble_ex=1, muldiv_start=0.
  4. Otherwise: stall_front=0, bubble_ex=0, muldiv_start=id_is_muldiv.
- Mul/div counter:
  - muldiv_start → md_cnt=MULDIV_LAT.
  - Else if md_cnt!=0 → md_cnt-- (counts through freezes).
  - muldiv_busy = (md_cnt!=0), registered.
  - MFHI in ID during the cycle md_cnt goes 1→0 still stalls; it proceeds the next cycle.
- Latency: all stall/flush outputs are combinational from the current inputs and registered state (0-cycle). Load-use stall lasts exactly 1 cycle.
- Reset mid-operation: an in-flight mul/div and memory wait are abandoned; md_cnt=0 and state=RUN immediately.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- Defined: perf_stall_cycles is a 32-bit counter.
  - Reset to 0; increments each cycle stall_front | freeze_back = 1.
  - Saturates at 0xFFFFFFFF.
  - Counts during MEMWAIT, hazard stalls and freeze.
- Undefined: perf_stall_cycles tied to 0 and no counter flops are generated.

Test Plan:
- Load-use: ex_is_load=1, ex_dst=8, id_uses_rs=1, id_rs=8 → stall_front=1 and bubble_ex=1 for exactly 1 cycle. With ex_dst=0 there is no stall.
- Mul/div with MULDIV_LAT=4:
  - id_is_muldiv=1 at cycle 0 → muldiv_start=1, busy on cycles 1..4.
  - MFHI in ID at cycle 1 → stall_front=1 on cycles 1..4, released on cycle 5.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 → freeze_back=1 for 3 cycles and 0 on the ready cycle; mem_err=0.
- Timeout with MEM_TIMEOUT=5: mem_ready held 0 → mem_err=1 after wait_cnt reaches 5, state RUN, freeze released. mem_err stays 1 until rst_n=0.
- Priority cases:
  - ex_branch_taken=1 with hz_ld=1 → flush_ifid=1, bubble_ex=1, stall_front=0.
  - Add freeze_back=1 → stall_front=1, flush_ifid=0.
- STALL_PERF_CNT_EN defined:
  - 3 memory wait cycles plus 1 load stall → perf_stall_cycles=4.
  - Async reset mid-MEMWAIT → counter=0, freeze_back=0 immediately.
